// File: rtl/prores_enc_pkg.sv
// prores_enc_pkg: shared constants and types for the ProRes
// entropy back end (codeword widths, bit packer states).
package prores_enc_pkg;

  localparam int WORD_W = 32;
  localparam int CODE_W = 24;
  localparam int LEN_W  = 6;
  localparam int ACC_W  = 64;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    TAIL
  } packer_state_t;

endpackage

// File: rtl/prores_bit_packer_outreg.sv
// prores_bit_packer_outreg: one-entry output slice holding a packed
// word, its last flag and byte count under valid/ready.
module prores_bit_packer_outreg #(
  parameter int W = prores_enc_pkg::WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  input  logic [2:0]   i_nbytes,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic [2:0]   o_nbytes
);

  // Load only when the top has found the slot free; hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_last   <= 1'b0;
      o_nbytes <= '0;
    end else if (i_load) begin
      o_valid  <= 1'b1;
      o_data   <= i_data;
      o_last   <= i_last;
      o_nbytes <= i_nbytes;
    end else if (i_ready) begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/prores_bit_packer.sv
// prores_bit_packer: packs (code, len) pairs MSB-first into 32-bit words.
// Define PRORES_BIT_PACKER_BITCOUNT_EN to add the bit_count output.
module prores_bit_packer
  import prores_enc_pkg::packer_state_t;
  import prores_enc_pkg::RUN;
  import prores_enc_pkg::FLUSH;
  import prores_enc_pkg::TAIL;
  import prores_enc_pkg::ACC_W;
#(
  parameter int WORD_W = 32,
  parameter int CODE_W = 24,
  parameter int LEN_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic [2:0]        out_nbytes,
  output logic              flush_done
`ifdef PRORES_BIT_PACKER_BITCOUNT_EN
  ,
  output logic [31:0]       bit_count
`endif
);

  localparam int FILL_W = $clog2(ACC_W) + 1;
  localparam int SH_W   = FILL_W + 1;

  localparam logic [FILL_W-1:0] F_WORD  = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] F_CODE  = FILL_W'(CODE_W);
  localparam logic [FILL_W-1:0] F_READY = FILL_W'(ACC_W - CODE_W);
  localparam logic [SH_W-1:0]   S_ACC   = SH_W'(ACC_W);

  packer_state_t      r_state;
  packer_state_t      w_state_n;
  logic [ACC_W-1:0]   r_acc;
  logic [FILL_W-1:0]  r_fill;
  logic               r_in_ready;
  logic               r_flush_done;

  logic [FILL_W-1:0]  w_len;
  logic [CODE_W-1:0]  w_code;
  logic [SH_W-1:0]    w_shamt;
  logic [ACC_W-1:0]   w_ins;
  logic [ACC_W-1:0]   w_sum_acc;
  logic [FILL_W-1:0]  w_sum_fill;
  logic               w_accept;
  logic               w_full;
  logic               w_out_free;
  logic               w_drain;
  logic               w_load;
  logic [WORD_W-1:0]  w_ld_data;
  logic               w_ld_last;
  logic [2:0]         w_ld_nb;
  logic               w_done;
  logic [ACC_W-1:0]   w_acc_n;
  logic [FILL_W-1:0]  w_fill_n;

  assign in_ready   = r_in_ready;
  assign flush_done = r_flush_done;

  // Clamp, mask and position the incoming code below the filled bits.
  always_comb begin
    w_accept = in_valid & r_in_ready;
    w_len    = (FILL_W'(in_len) > F_CODE) ? F_CODE : FILL_W'(in_len);
    w_code   = in_code & ~({CODE_W{1'b1}} << w_len);
    w_shamt  = S_ACC - SH_W'(r_fill) - SH_W'(w_len);
    w_ins    = ACC_W'(w_code) << w_shamt;
    w_sum_acc  = r_acc | (w_accept ? w_ins : '0);
    w_sum_fill = r_fill + (w_accept ? w_len : '0);
    w_full     = w_sum_fill >= F_WORD;
    w_out_free = ~out_valid | out_ready;
  end

  // Drain full words, sequence the flush and build the next acc state.
  always_comb begin
    w_state_n = r_state;
    w_drain   = w_full & w_out_free;
    w_load    = w_drain;
    w_ld_data = w_sum_acc[ACC_W-1 -: WORD_W];
    w_ld_last = 1'b0;
    w_ld_nb   = 3'd4;
    w_done    = 1'b0;
    w_acc_n   = w_drain ? (w_sum_acc << WORD_W) : w_sum_acc;
    w_fill_n  = w_drain ? (w_sum_fill - F_WORD) : w_sum_fill;
    unique case (r_state)
      RUN: begin
        if (in_flush & (w_accept | ~in_valid))
          w_state_n = FLUSH;
      end
      FLUSH: begin
        if (!w_full && w_out_free) begin
          if (r_fill != '0) begin
            w_load    = 1'b1;
            w_ld_last = 1'b1;
            w_ld_nb   = 3'((r_fill + FILL_W'(7)) >> 3);
            w_state_n = TAIL;
          end else begin
            w_done    = 1'b1;
            w_state_n = RUN;
          end
        end
      end
      TAIL: begin
        if (out_valid & out_ready) begin
          w_done    = 1'b1;
          w_acc_n   = '0;
          w_fill_n  = '0;
          w_state_n = RUN;
        end
      end
      default: w_state_n = RUN;
    endcase
  end

  // State, accumulator and the registered in_ready / flush_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_acc        <= '0;
      r_fill       <= '0;
      r_in_ready   <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_acc        <= w_acc_n;
      r_fill       <= w_fill_n;
      r_in_ready   <= (w_state_n == RUN) & (w_fill_n <= F_READY);
      r_flush_done <= w_done;
    end
  end

`ifdef PRORES_BIT_PACKER_BITCOUNT_EN
  logic [31:0] r_bit_count;

  assign bit_count = r_bit_count;

  // Count accepted code bits per slice; restart with each flush_done.
  always_ff @(posedge clk) begin
    if (reset)
      r_bit_count <= '0;
    else if (w_done)
      r_bit_count <= '0;
    else if (w_accept)
      r_bit_count <= r_bit_count + 32'(w_len);
  end
`endif

  prores_bit_packer_outreg #(
    .W(WORD_W)
  ) u_outreg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_data   (w_ld_data),
    .i_last   (w_ld_last),
    .i_nbytes (w_ld_nb),
    .i_ready  (out_ready),
    .o_valid  (out_valid),
    .o_data   (out_data),
    .o_last   (out_last),
    .o_nbytes (out_nbytes)
  );

endmodule

// File: tb/tb_prores_bit_packer.sv
// tb_prores_bit_packer: directed tables, corner sequences and random
// traffic checked against a bit-queue model of the packed stream.
`timescale 1ns/1ps
module tb_prores_bit_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] in_code = '0;
  logic [5:0]  in_len = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_last;
  logic        flush_done;
  logic [31:0] out_data;
  logic [2:0]  out_nbytes;
`ifdef PRORES_BIT_PACKER_BITCOUNT_EN
  logic [31:0] bit_count;
`endif

  always #5 clk = ~clk;

  prores_bit_packer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_len     (in_len),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_nbytes (out_nbytes),
    .flush_done (flush_done)
`ifdef PRORES_BIT_PACKER_BITCOUNT_EN
    ,
    .bit_count  (bit_count)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [2:0]  nb;
  } word_t;

  typedef struct {
    logic [23:0] code;
    logic [5:0]  len;
    logic [31:0] exp_data;
    logic [2:0]  exp_nb;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: the stream is a plain queue of bits.
  bit    bq[$];
  word_t exq[$];
  int    pending = 0;
  int    words_rx = 0;
  word_t last_w;
  logic  prev_stall = 1'b0;
  word_t prev_w;
  longint mbits = 0;

  function automatic word_t take_bits(input int n);
    word_t w;
    w.data = '0;
    for (int i = 0; i < n; i++)
      w.data[31-i] = bq.pop_front();
    w.last = (n < 32) || (n == 32 && 1'b0);
    w.nb = 3'((n + 7) / 8);
    return w;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      bq.delete();
      exq.delete();
      pending = 0;
      prev_stall = 1'b0;
      mbits = 0;
    end else begin
      if (flush_done) begin
        chk("flush_done_expected", 64'(pending > 0), 1);
        if (pending > 0) pending--;
        mbits = 0;
      end
`ifdef PRORES_BIT_PACKER_BITCOUNT_EN
      chk("bit_count", bit_count, mbits[31:0]);
`endif
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_word", {out_data, out_last, out_nbytes},
            {prev_w.data, prev_w.last, prev_w.nb});
      end
      prev_stall = out_valid && !out_ready;
      prev_w = '{out_data, out_last, out_nbytes};
      if (out_valid && out_ready) begin
        words_rx++;
        last_w = '{out_data, out_last, out_nbytes};
        chk("word_expected", 64'(exq.size() > 0), 1);
        if (exq.size() > 0) begin
          word_t e;
          e = exq.pop_front();
          chk("word_data", out_data, e.data);
          chk("word_last", out_last, e.last);
          chk("word_nbytes", out_nbytes, e.nb);
        end
      end
      if (in_valid && in_ready) begin
        int l;
        l = (in_len > 24) ? 24 : int'(in_len);
        for (int i = l - 1; i >= 0; i--)
          bq.push_back(in_code[i]);
        mbits += l;
        while (bq.size() >= 32) begin
          word_t w;
          w = take_bits(32);
          w.last = 1'b0;
          w.nb = 3'd4;
          exq.push_back(w);
        end
      end
      if (in_flush && ((in_valid && in_ready) ||
                       (!in_valid && pending == 0))) begin
        pending++;
        if (bq.size() > 0)
          exq.push_back(take_bits(bq.size()));
      end
    end
  end

  task automatic send(input logic [23:0] c, input logic [5:0] l,
                      input logic f);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_code = c;
    in_len = l;
    in_flush = f;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_accepted", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!flush_done && n < 100);
    chk(nm, flush_done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic flush_alone();
    int n;
    n = 0;
    while (pending != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("flush_idle", 64'(pending), 0);
    @(posedge clk);
    #1;
    in_flush = 1'b1;
    @(posedge clk);
    #1;
    in_flush = 1'b0;
    wait_done("flush_alone_done");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[9];
  int   w0;
  int   nacc;
  logic saw_drop;

  initial begin
    vt[0] = '{24'h000005, 6'd3,  32'hA0000000, 3'd1};
    vt[1] = '{24'hFFFFFF, 6'd24, 32'hFFFFFF00, 3'd3};
    vt[2] = '{24'h0003FF, 6'd9,  32'hFF800000, 3'd2};
    vt[3] = '{24'hABCDEF, 6'd40, 32'hABCDEF00, 3'd3};
    vt[4] = '{24'h01FFFF, 6'd17, 32'hFFFF8000, 3'd3};
    vt[5] = '{24'h000001, 6'd8,  32'h01000000, 3'd1};
    vt[6] = '{24'h123456, 6'd0,  32'h00000000, 3'd0};
    vt[7] = '{24'hFFF0F0, 6'd12, 32'h0F000000, 3'd2};
    vt[8] = '{24'h800001, 6'd63, 32'h80000100, 3'd3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_flush_done", flush_done, 0);
    chk("idle_nbytes", out_nbytes, 0);

    w0 = words_rx;
    for (int i = 0; i < 32; i++)
      send(24'h1, 6'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("ones_count", 64'(words_rx - w0), 1);
    chk("ones_data", last_w.data, 32'hFFFFFFFF);
    chk("ones_nbytes", last_w.nb, 4);
    chk("ones_last", last_w.last, 0);

    send(24'h12, 6'd8, 1'b0);
    send(24'h34, 6'd8, 1'b0);
    send(24'h56, 6'd8, 1'b0);
    chk("lat_not_early", out_valid, 0);
    send(24'h78, 6'd8, 1'b0);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 32'h12345678);
    send(24'hFFFFFF, 6'd4, 1'b0);
    flush_alone();
    chk("tail_data", last_w.data, 32'hF0000000);
    chk("tail_last", last_w.last, 1);
    chk("tail_nbytes", last_w.nb, 1);

    foreach (vt[i]) begin
      w0 = words_rx;
      send(vt[i].code, vt[i].len, 1'b1);
      wait_done("vec_flush_done");
      chk("vec_words", 64'(words_rx - w0), (vt[i].exp_nb != 0) ? 1 : 0);
      if (vt[i].exp_nb != 0) begin
        chk("vec_data", last_w.data, vt[i].exp_data);
        chk("vec_nbytes", last_w.nb, vt[i].exp_nb);
        chk("vec_last", last_w.last, 1);
      end
    end

    w0 = words_rx;
    nacc = 0;
    saw_drop = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_code = 24'hAAAAAA;
    in_len = 6'd24;
    for (int cyc = 0; cyc < 60 && nacc < 8; cyc++) begin
      if (cyc == 20) out_ready = 1'b1;
      @(negedge clk);
      if (cyc == 19) chk("stall_no_accept", in_ready, 0);
      if (in_ready) nacc++;
      if (!in_ready && out_valid && !out_ready) saw_drop = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("stall_ready_drop", saw_drop, 1);
    chk("stall_accepts", 64'(nacc), 8);
    for (int n = 0; n < 50 && words_rx - w0 < 6; n++)
      @(posedge clk);
    #1;
    chk("stall_words", 64'(words_rx - w0), 6);

    out_ready = 1'b0;
    send(24'hFFFFFF, 6'd24, 1'b0);
    send(24'hFFFFFF, 6'd24, 1'b0);
    send(24'h00000F, 6'd4, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_nbytes", out_nbytes, 0);
    chk("mid_rst_done", flush_done, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(24'h001234, 6'd16, 1'b0);
    send(24'h005678, 6'd16, 1'b0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 32'h12345678);
    chk("post_rst_last", out_last, 0);

    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom % 4) != 0;
      in_code = 24'($urandom);
      in_len = 6'($urandom_range(0, 31));
      in_flush = ($urandom % 20) == 0;
      out_ready = ($urandom % 4) != 0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_flush = 1'b0;
    out_ready = 1'b1;
    flush_alone();
    repeat (3) @(posedge clk);
    #1;
    chk("end_exq_empty", 64'(exq.size()), 0);
    chk("end_bits_empty", 64'(bq.size()), 0);
    chk("end_pending", 64'(pending), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
